// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory controller: one load/store per access, dmem handshake, store lane/mask
// generation, raw load-word capture. Optional misalignment trap under DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        timeout,
    output logic        misaligned,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  ld_offset,
    output logic [2:0]  ld_funct3,
    output logic [31:0] ld_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_load_reg;
    logic [1:0]       offset_reg;
    logic [2:0]       funct3_reg;
    logic             timeout_flag_reg;
    logic             misalign_flag_reg;

    logic             request;
    logic             misalign_req;
    logic             timeout_hit;
    logic [3:0]       mask_calc;
    logic [31:0]      wdata_calc;

    assign request     = req_valid & (req_load | req_store);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TO_LAST);

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign_req = 1'b0;
        if (request) begin
            case (req_funct3)
                3'b001:  misalign_req = req_addr[0];
                3'b101:  misalign_req = req_load & req_addr[0];
                3'b010:  misalign_req = |req_addr[1:0];
                default: misalign_req = 1'b0;
            endcase
        end
    end
`else
    assign misalign_req = 1'b0;
`endif

    // Byte enables and lane replication; unused low address bits are simply ignored.
    always_comb begin
        mask_calc  = 4'b0000;
        wdata_calc = req_wdata;
        case (req_funct3)
            3'b000: begin
                mask_calc  = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                mask_calc  = 4'b0011 << {req_addr[1], 1'b0};
                wdata_calc = {2{req_wdata[15:0]}};
            end
            3'b010:  mask_calc = 4'b1111;
            default: mask_calc = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        misaligned = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = request;
                if (request) state_next = misalign_req ? DONE : ACCESS;
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem_resp || timeout_hit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                timeout    = timeout_flag_reg;
                misaligned = misalign_flag_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg           <= '0;
            is_load_reg       <= 1'b0;
            offset_reg        <= 2'b00;
            funct3_reg        <= 3'b000;
            timeout_flag_reg  <= 1'b0;
            misalign_flag_reg <= 1'b0;
            dmem_read         <= 1'b0;
            dmem_write        <= 1'b0;
            dmem_address      <= 32'h0;
            dmem_wmask        <= 4'b0000;
            dmem_wdata        <= 32'h0;
            ld_offset         <= 2'b00;
            ld_funct3         <= 3'b000;
            ld_rdata          <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg           <= '0;
                    timeout_flag_reg  <= 1'b0;
                    misalign_flag_reg <= 1'b0;
                    if (request) begin
                        is_load_reg  <= req_load;
                        offset_reg   <= req_addr[1:0];
                        funct3_reg   <= req_funct3;
                        dmem_address <= {req_addr[31:2], 2'b00};
                        if (misalign_req) begin
                            misalign_flag_reg <= 1'b1;
                        end else begin
                            dmem_read  <= req_load;
                            dmem_write <= ~req_load;
                            dmem_wmask <= req_load ? 4'b0000 : mask_calc;
                            dmem_wdata <= req_load ? 32'h0 : wdata_calc;
                        end
                    end
                end
                ACCESS: begin
                    // A response in the timeout cycle still counts as a normal completion.
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        cnt_reg    <= '0;
                        if (is_load_reg) begin
                            ld_rdata  <= dmem_rdata;
                            ld_offset <= offset_reg;
                            ld_funct3 <= funct3_reg;
                        end
                    end else if (timeout_hit) begin
                        dmem_read        <= 1'b0;
                        dmem_write       <= 1'b0;
                        cnt_reg          <= '0;
                        timeout_flag_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    cnt_reg <= '0;
                end
                default: cnt_reg <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl against a lane-level behavioural model.
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, timeout, misaligned;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic [1:0]  ld_offset;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_rdata;
    logic [1:0]  m_off;
    logic [2:0]  m_f3;

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .timeout(timeout), .misaligned(misaligned),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .ld_offset(ld_offset), .ld_funct3(ld_funct3), .ld_rdata(ld_rdata)
    );

    always #5 clk = ~clk;

    function automatic int access_size(input logic [2:0] f3);
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    // Enabled lanes: the naturally aligned group of 'size' bytes containing the addressed byte.
    function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
        int sz = access_size(f3);
        int base;
        logic [3:0] m = 4'b0000;
        if (sz == 0) return m;
        base = (int'(a % 4) / sz) * sz;
        for (int i = 0; i < 4; i++)
            if (i >= base && i < base + sz) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = access_size(f3);
        logic [31:0] r = 32'h0;
        if (sz == 0) sz = 4;
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic bit model_misaligned(input bit is_ld, input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || (is_ld && f3 == 3'd5)) && (a % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_txn(input string tag, input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int dly,
                           input logic [31:0] rd);
        bit          is_ld   = ld;
        bit          mis     = model_misaligned(ld, f3, a);
        bit          timed   = (dly > TO);
        int          end_c   = timed ? TO : dly;
        logic [31:0] e_addr  = a & 32'hFFFF_FFFC;
        logic [3:0]  e_mask  = is_ld ? 4'b0000 : model_mask(f3, a);
        logic [31:0] e_wdata = model_wdata(f3, wd);

        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = a; req_wdata = wd;
        #1;
        n_cmp++;
        if ({stall, done, dmem_read, dmem_write} !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s cycle0 {stall,done,rd,wr}: got %b need 1000", tag, {stall, done, dmem_read, dmem_write});
        end

        if (mis) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            n_cmp++;
            if ({done, misaligned, timeout, stall, dmem_read, dmem_write} !== 6'b110000) begin
                n_bad++;
                $display("FAIL %s misalign_done {done,mis,to,stall,rd,wr}: got %b need 110000", tag,
                         {done, misaligned, timeout, stall, dmem_read, dmem_write});
            end
        end else begin
            for (int c = 1; c <= end_c; c++) begin
                @(posedge clk); #1;
                n_cmp++;
                if ({stall, done, dmem_read, dmem_write} !== {2'b10, is_ld, ~is_ld}) begin
                    n_bad++;
                    $display("FAIL %s access_c%0d {stall,done,rd,wr}: got %b need %b", tag, c,
                             {stall, done, dmem_read, dmem_write}, {2'b10, is_ld, ~is_ld});
                end
                n_cmp++;
                if (dmem_address !== e_addr || dmem_wmask !== e_mask) begin
                    n_bad++;
                    $display("FAIL %s addr_mask_c%0d: got %h/%b need %h/%b", tag, c,
                             dmem_address, dmem_wmask, e_addr, e_mask);
                end
                if (!is_ld) begin
                    n_cmp++;
                    if (dmem_wdata !== e_wdata) begin
                        n_bad++;
                        $display("FAIL %s wdata_c%0d: got %h need %h", tag, c, dmem_wdata, e_wdata);
                    end
                end
                // Pipeline inputs wander during the access and must be ignored.
                req_valid = 1'($urandom); req_load = 1'($urandom); req_store = 1'($urandom);
                req_addr = $urandom; req_funct3 = 3'($urandom); req_wdata = $urandom;
                if (c == dly) begin
                    dmem_resp = 1'b1; dmem_rdata = rd;
                end else begin
                    dmem_resp = 1'b0; dmem_rdata = $urandom;
                end
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (!timed && is_ld) begin
                m_rdata = rd; m_off = a[1:0]; m_f3 = f3;
            end
            dmem_resp = timed;
            dmem_rdata = $urandom;
            n_cmp++;
            if ({done, timeout, misaligned, stall, dmem_read, dmem_write} !== {1'b1, timed, 4'b0000}) begin
                n_bad++;
                $display("FAIL %s done_cycle {done,to,mis,stall,rd,wr}: got %b need %b", tag,
                         {done, timeout, misaligned, stall, dmem_read, dmem_write}, {1'b1, timed, 4'b0000});
            end
        end
        n_cmp++;
        if (ld_rdata !== m_rdata || ld_offset !== m_off || ld_funct3 !== m_f3) begin
            n_bad++;
            $display("FAIL %s ld_fields: got %h/%0d/%0d need %h/%0d/%0d", tag,
                     ld_rdata, ld_offset, ld_funct3, m_rdata, m_off, m_f3);
        end
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        n_cmp++;
        if ({stall, done, timeout, dmem_read, dmem_write} !== 5'b00000 || ld_rdata !== m_rdata) begin
            n_bad++;
            $display("FAIL %s idle_after {stall,done,to,rd,wr}: got %b need 00000, ld_rdata %h need %h", tag,
                     {stall, done, timeout, dmem_read, dmem_write}, ld_rdata, m_rdata);
        end
        $display("txn %s ld=%0b st=%0b f3=%0d addr=%h wd=%h dly=%0d", tag, ld, st, f3, a, wd, dly);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        dmem_resp = 1'b0; dmem_rdata = 32'h0;
        m_rdata = 32'h0; m_off = 2'd0; m_f3 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({stall, done, timeout, misaligned, dmem_read, dmem_write} !== 6'b0 ||
            dmem_address !== 32'h0 || dmem_wmask !== 4'h0 || dmem_wdata !== 32'h0 ||
            ld_rdata !== 32'h0 || ld_offset !== 2'd0 || ld_funct3 !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state: ctl=%b addr=%h mask=%b wdata=%h ld=%h/%0d/%0d need all zero",
                     {stall, done, timeout, misaligned, dmem_read, dmem_write},
                     dmem_address, dmem_wmask, dmem_wdata, ld_rdata, ld_offset, ld_funct3);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_directed();
        run_txn("lw_1004", 1'b1, 1'b0, 3'd2, 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF);
        run_txn("sb_2003", 1'b0, 1'b1, 3'd0, 32'h0000_2003, 32'h0000_00A5, 1, 32'h0);
        run_txn("sh_2002", 1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_1234, 3, 32'h0);
        run_txn("ld_st_both", 1'b1, 1'b1, 3'd4, 32'h0000_3003, 32'hFFFF_FFFF, 1, 32'h0BAD_F00D);
        run_txn("sw_bad_f3", 1'b0, 1'b1, 3'd3, 32'h0000_4008, 32'hCAFE_0001, 2, 32'h0);
        run_txn("ld_bad_f3", 1'b1, 1'b0, 3'd7, 32'h0000_500C, 32'h0, 1, 32'h1357_9BDF);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 1'b1, 1'b0, 3'd2, 32'h0000_6000, 32'h0, TO + 3, 32'h0);
        run_txn("resp_at_limit", 1'b1, 1'b0, 3'd5, 32'h0000_6002, 32'h0, TO, 32'h2468_ACE0);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
        req_funct3 = 3'd2; req_addr = 32'h0000_7000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (dmem_read !== 1'b1 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid pre: rd=%b stall=%b need 1/1", dmem_read, stall);
        end
        #1 rst = 1'b1;
        #1;
        m_rdata = 32'h0; m_off = 2'd0; m_f3 = 3'd0;
        n_cmp++;
        if ({stall, done, dmem_read, dmem_write} !== 4'b0000 || ld_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid async {stall,done,rd,wr}=%b ld_rdata=%h need 0000/0",
                     {stall, done, dmem_read, dmem_write}, ld_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        dmem_resp = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        n_cmp++;
        if (ld_rdata !== 32'h0 || {stall, done, dmem_read} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_mid stray_resp: ld_rdata=%h ctl=%b need 0/000", ld_rdata, {stall, done, dmem_read});
        end
        $display("txn reset mid access");
        run_txn("after_rst", 1'b1, 1'b0, 3'd0, 32'h0000_7001, 32'h0, 1, 32'h1122_3344);
    endtask

    task automatic test_misaligned();
`ifdef DMEM_MISALIGN_TRAP_EN
        run_txn("lw_1001_trap", 1'b1, 1'b0, 3'd2, 32'h0000_1001, 32'h0, 1, 32'hFFFF_0000);
        run_txn("sh_2001_trap", 1'b0, 1'b1, 3'd1, 32'h0000_2001, 32'h0000_BEEF, 1, 32'h0);
`else
        run_txn("lw_1001_noalign", 1'b1, 1'b0, 3'd2, 32'h0000_1001, 32'h0, 1, 32'h8765_4321);
        run_txn("sh_2001_noalign", 1'b0, 1'b1, 3'd1, 32'h0000_2001, 32'h0000_BEEF, 2, 32'h0);
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit ld = 1'($urandom);
            bit st = ld ? 1'($urandom_range(1, 0) == 1 && $urandom_range(3, 0) == 0) : 1'b1;
            run_txn($sformatf("rand%0d", n), ld, st, 3'($urandom_range(7, 0)), $urandom, $urandom,
                    $urandom_range(TO + 2, 1), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_access();
        test_misaligned();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
